// File: rtl/apb_master_bridge.sv
// APB3 master: turns the LSU's paddr/pwdata/sel/control registers into single APB transfers.
// Optional ACCESS-phase timeout is compiled in with APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_apb_paddr,
    input  logic [DATA_W-1:0] i_apb_pwdata,
    input  logic [1:0]        i_apb_sel,
    input  logic [1:0]        i_apb_control,
    output logic [NUM_SLV-1:0] o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [ADDR_W-1:0] o_paddr,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          sel_q, sel_d;
    logic                write_q, write_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                start_evt;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]    wait_q, wait_d;
`endif

    // Rising edge of the level-style start bit; a start held across reset release counts once.
    assign start_evt = i_apb_control[0] & ~start_q;

    always_comb begin
        state_d = state_q;
        start_d = i_apb_control[0];
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        write_d = write_q;
        done_d  = done_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef APB_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    addr_d  = i_apb_paddr;
                    wdata_d = i_apb_pwdata;
                    sel_d   = i_apb_sel;
                    write_d = i_apb_control[1];
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
`ifdef APB_TIMEOUT_EN
                wait_d  = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                if (i_pready) begin
                    if (!write_q) begin
                        rdata_d = i_prdata;
                    end
                    err_d   = i_pslverr;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                // Abort once this is the TIMEOUT-th consecutive ACCESS cycle without PREADY.
                else if (wait_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d  = wait_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef APB_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Out-of-range sel leaves every PSEL low while the FSM still steps through the transfer.
    always_comb begin
        o_psel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            o_psel[i] = (state_q != IDLE) && (int'(sel_q) == i);
        end
    end

    assign o_penable = (state_q == ACCESS);
    assign o_busy    = (state_q != IDLE);
    assign o_pwrite  = write_q;
    assign o_paddr   = addr_q;
    assign o_pwdata  = wdata_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_rdata   = rdata_q;

endmodule
